// File: rtl/ksk_bram_pipe_bank_if.sv
// rtl/ksk_bram_pipe_bank_if.sv - write, tagged read-request and read-response bus of the KSK bank buffer
// master is the loader/datapath side, slave is the buffer.
interface ksk_bram_pipe_bank_if #(
  parameter int NUM_LANE   = 128,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int BANK_WIDTH = 1,
  parameter int TAG_WIDTH  = 8,
  parameter int CNT_WIDTH  = 3
);
  logic                           wr_valid;
  logic                           wr_ready;
  logic [BANK_WIDTH-1:0]          wr_bank;
  logic [ADDR_WIDTH-1:0]          wr_addr;
  logic [NUM_LANE-1:0]            wr_mask;
  logic [DATA_WIDTH*NUM_LANE-1:0] wr_data;
  logic                           rd_req_valid;
  logic                           rd_req_ready;
  logic [BANK_WIDTH-1:0]          rd_req_bank;
  logic [ADDR_WIDTH-1:0]          rd_req_addr;
  logic [TAG_WIDTH-1:0]           rd_req_tag;
  logic                           rd_rsp_valid;
  logic                           rd_rsp_ready;
  logic [DATA_WIDTH*NUM_LANE-1:0] rd_rsp_data;
  logic [TAG_WIDTH-1:0]           rd_rsp_tag;
  logic [CNT_WIDTH-1:0]           rd_outstanding;
  logic                           addr_err;

  modport master (
    output wr_valid, wr_bank, wr_addr, wr_mask, wr_data,
    output rd_req_valid, rd_req_bank, rd_req_addr, rd_req_tag, rd_rsp_ready,
    input  wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_tag,
    input  rd_outstanding, addr_err
  );

  modport slave (
    input  wr_valid, wr_bank, wr_addr, wr_mask, wr_data,
    input  rd_req_valid, rd_req_bank, rd_req_addr, rd_req_tag, rd_rsp_ready,
    output wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_tag,
    output rd_outstanding, addr_err
  );
endinterface

// File: rtl/ksk_bram_pipe_bank.sv
// rtl/ksk_bram_pipe_bank.sv - banked multi-lane KSK BRAM with pipelined tagged reads
// Responses land in a credit-protected FWFT FIFO so the stall-free read pipe never overflows it.
module ksk_bram_pipe_bank #(
  parameter int NUM_LANE   = 128,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_BANK   = 2,
  parameter int BANK_WIDTH = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
  parameter int NB_PIPE    = 3,
  parameter int TAG_WIDTH  = 8,
  parameter int RSP_DEPTH  = NB_PIPE + 2
) (
  input logic                 clk,
  input logic                 rst_n,
  ksk_bram_pipe_bank_if.slave bus
);
  localparam int LW = DATA_WIDTH * NUM_LANE;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  function automatic logic in_range(input logic [BANK_WIDTH-1:0] b, input logic [ADDR_WIDTH-1:0] a);
    return ({{(32-BANK_WIDTH){1'b0}}, b} < 32'(NUM_BANK)) &&
           ({{(32-ADDR_WIDTH){1'b0}}, a} < 32'(DEPTH));
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic                  ready_q;
  logic [NB_PIPE-1:0]    pv_q, pv_d;
  logic [NB_PIPE-1:0]    perr_q;
  logic [TAG_WIDTH-1:0]  ptag_q [NB_PIPE];
  logic [BANK_WIDTH-1:0] s0_bank_q;
  logic [LW-1:0]         bram_q [NUM_BANK];
  logic [LW-1:0]         s0_data, pipe_data, push_data;
  logic [TAG_WIDTH+LW-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d, out_q, out_d;
  logic                  err_q, err_d;
  logic                  wr_fire, rd_fire, wr_ok, rd_ok, push, pop;

  assign wr_ok   = in_range(bus.wr_bank, bus.wr_addr);
  assign rd_ok   = in_range(bus.rd_req_bank, bus.rd_req_addr);
  assign wr_fire = bus.wr_valid && ready_q;
  assign rd_fire = bus.rd_req_valid && bus.rd_req_ready;
  assign push    = pv_q[NB_PIPE-1];
  assign pop     = (cnt_q != '0) && bus.rd_rsp_ready;

  // A same-bank write owns the single BRAM port, so the read is held off that cycle.
  assign bus.wr_ready     = ready_q;
  assign bus.rd_req_ready = ready_q && (out_q < CW'(RSP_DEPTH)) &&
                            !(bus.wr_valid && (bus.wr_bank == bus.rd_req_bank));

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] rd_q;
      logic                  we, re;
      assign we = wr_fire && wr_ok && (bus.wr_bank == BANK_WIDTH'(b)) && bus.wr_mask[l];
      assign re = rd_fire && rd_ok && (bus.rd_req_bank == BANK_WIDTH'(b));
      always_ff @(posedge clk) begin
        if (we) mem[bus.wr_addr] <= bus.wr_data[l*DATA_WIDTH +: DATA_WIDTH];
        else if (re) rd_q <= mem[bus.rd_req_addr];
      end
      assign bram_q[b][l*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end
  end

  // Stage 0 of the pipe is the BRAM output register itself.
  assign s0_data = bram_q[s0_bank_q];

  if (NB_PIPE == 1) begin : g_nopipe
    assign pipe_data = s0_data;
  end else begin : g_pipe
    logic [LW-1:0] data_q [NB_PIPE-1];
    always_ff @(posedge clk) begin
      data_q[0] <= s0_data;
      for (int k = 1; k < NB_PIPE - 1; k++) data_q[k] <= data_q[k-1];
    end
    assign pipe_data = data_q[NB_PIPE-2];
  end

  assign push_data = perr_q[NB_PIPE-1] ? '0 : pipe_data;

  always_ff @(posedge clk) begin
    ptag_q[0] <= bus.rd_req_tag;
    perr_q[0] <= ~rd_ok;
    s0_bank_q <= bus.rd_req_bank;
    for (int k = 1; k < NB_PIPE; k++) begin
      ptag_q[k] <= ptag_q[k-1];
      perr_q[k] <= perr_q[k-1];
    end
    if (push) fifo_mem[wptr_q] <= {ptag_q[NB_PIPE-1], push_data};
  end

  always_comb begin
    pv_d   = NB_PIPE'({pv_q, rd_fire});
    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    out_d  = out_q + CW'(rd_fire) - CW'(pop);
    err_d  = err_q | (wr_fire & ~wr_ok) | (rd_fire & ~rd_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      pv_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      pv_q    <= pv_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign bus.rd_rsp_valid               = (cnt_q != '0);
  assign {bus.rd_rsp_tag, bus.rd_rsp_data} = fifo_mem[rptr_q];
  assign bus.rd_outstanding             = out_q;
  assign bus.addr_err                   = err_q;
endmodule
